// File: rtl/updown_counter_ctrl.sv
// Control unit for the up/down counter: turns debounced button levels into
// run/stop, clear and direction commands, and prescales the count-enable tick.
module updown_counter_ctrl #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run_stop,
   input  logic       btn_clear,
   input  logic       btn_mode,
   output logic       o_tick,
   output logic       o_mode,
   output logic       o_clear,
   output logic [1:0] o_state
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_mode;
   logic [CNT_W-1:0] r_div_cnt;
   logic             r_prev_run;
   logic             r_prev_clr;
   logic             r_prev_mode;

   logic w_ev_run;
   logic w_ev_clr;
   logic w_ev_mode;
   logic w_div_wrap;

   // Rising-edge detection on the debounced levels
   assign w_ev_run   = btn_run_stop & ~r_prev_run;
   assign w_ev_clr   = btn_clear    & ~r_prev_clr;
   assign w_ev_mode  = btn_mode     & ~r_prev_mode;
   assign w_div_wrap = (r_div_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_STOP;
         r_mode      <= 1'b0;
         r_div_cnt   <= '0;
         r_prev_run  <= 1'b0;
         r_prev_clr  <= 1'b0;
         r_prev_mode <= 1'b0;
      end else begin
         r_prev_run  <= btn_run_stop;
         r_prev_clr  <= btn_clear;
         r_prev_mode <= btn_mode;

         // Direction toggles independently of the run/clear sequencing
         if (w_ev_mode) begin
            r_mode <= ~r_mode;
         end

         case (r_state)
            ST_STOP: begin
               if (w_ev_clr) begin
                  r_state <= ST_CLEAR;
               end else if (w_ev_run) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + CNT_W'(1);
               if (w_ev_clr) begin
                  r_state <= ST_CLEAR;
               end else if (w_ev_run) begin
                  r_state <= ST_STOP;
               end
            end
            ST_CLEAR: begin
               r_state   <= ST_STOP;
               r_div_cnt <= '0;
            end
            default: begin
               r_state   <= ST_STOP;
               r_div_cnt <= '0;
            end
         endcase
      end
   end

   assign o_tick  = (r_state == ST_RUN) && w_div_wrap;
   assign o_clear = (r_state == ST_CLEAR);
   assign o_mode  = r_mode;
   assign o_state = r_state;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Self-checking bench for updown_counter_ctrl: directed button scenarios
// followed by random button activity, compared against a cycle-count model.
module tb_updown_counter_ctrl;

   localparam int unsigned DIV = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_run_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_mode = 1'b0;
   logic       o_tick;
   logic       o_mode;
   logic       o_clear;
   logic [1:0] o_state;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Model: running/clearing flags, direction, and RUN cycles since last clear
   bit m_run   = 1'b0;
   bit m_clr   = 1'b0;
   bit m_mode  = 1'b0;
   int m_runs  = 0;
   bit m_lvl_run = 1'b0, m_lvl_clr = 1'b0, m_lvl_mode = 1'b0;

   updown_counter_ctrl #(.TICK_DIV(DIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_run_stop (btn_run_stop),
      .btn_clear    (btn_clear),
      .btn_mode     (btn_mode),
      .o_tick       (o_tick),
      .o_mode       (o_mode),
      .o_clear      (o_clear),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Advance the model across one clock edge with the levels that edge samples
   task automatic model_edge(input bit r, input bit c, input bit m, input bit rs);
      bit pr, pc, pm;
      if (rs) begin
         m_run = 0; m_clr = 0; m_mode = 0; m_runs = 0;
         m_lvl_run = 0; m_lvl_clr = 0; m_lvl_mode = 0;
         return;
      end
      pr = r & !m_lvl_run;
      pc = c & !m_lvl_clr;
      pm = m & !m_lvl_mode;
      m_lvl_run = r; m_lvl_clr = c; m_lvl_mode = m;
      if (pm) m_mode = !m_mode;
      if (m_clr) begin
         m_clr  = 0;
         m_runs = 0;
      end else if (m_run) begin
         m_runs++;
         if (pc) begin
            m_run = 0; m_clr = 1;
         end else if (pr) begin
            m_run = 0;
         end
      end else begin
         if (pc) m_clr = 1;
         else if (pr) m_run = 1;
      end
   endtask

   task automatic check_all();
      int exp_state;
      exp_state = m_clr ? 2 : (m_run ? 1 : 0);
      check("state", int'(o_state), exp_state);
      check("clear", int'(o_clear), int'(m_clr));
      check("mode",  int'(o_mode),  int'(m_mode));
      // Current RUN cycle is number m_runs+1; tick on every DIV-th one
      check("tick",  int'(o_tick),
            int'(m_run && (((m_runs + 1) % int'(DIV)) == 0)));
   endtask

   task automatic step(input bit r, input bit c, input bit m, input bit rs);
      @(negedge clk);
      btn_run_stop = r; btn_clear = c; btn_mode = m; reset = rs;
      @(posedge clk);
      model_edge(r, c, m, rs);
      cyc++;
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic press_run();
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
   endtask

   int ticks;
   bit r_lvl, c_lvl, m_lvl, rs_lvl;

   initial begin
      // Reset and quiet period
      step(0, 0, 0, 1);
      check("rst_state", int'(o_state), 0);
      check("rst_mode",  int'(o_mode),  0);
      check("rst_tick",  int'(o_tick),  0);
      check("rst_clear", int'(o_clear), 0);
      idle(20);

      // Run cadence: ticks in RUN cycles 4, 8, 12
      step(1, 0, 0, 0);
      check("run_entry", int'(o_state), 1);
      ticks = 0;
      for (int i = 2; i <= 12; i++) begin
         step(0, 0, 0, 0);
         if (o_tick) ticks++;
         if (i == 4 || i == 8 || i == 12) check("cadence_tick", int'(o_tick), 1);
      end
      check("cadence_count", ticks, 3);

      // Clear, then pause/resume with partial interval held
      step(0, 1, 0, 0);
      check("clr_pulse", int'(o_clear), 1);
      step(0, 0, 0, 0);
      check("clr_done", int'(o_state), 0);
      step(1, 0, 0, 0);
      idle(5);
      step(1, 0, 0, 0);
      check("paused", int'(o_state), 0);
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0);
         if (o_tick) ticks++;
      end
      check("pause_ticks", ticks, 0);
      step(1, 0, 0, 0);
      check("resume_c1", int'(o_tick), 0);
      step(0, 0, 0, 0);
      check("resume_c2", int'(o_tick), 1);
      idle(6);

      // Simultaneous clear and run_stop in RUN
      step(1, 1, 0, 0);
      check("simul_state", int'(o_state), 2);
      step(0, 0, 0, 0);
      check("simul_stop", int'(o_state), 0);
      press_run();
      idle(4);

      // Held buttons: one event each
      step(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
      check("held_run", int'(o_state), 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
      check("held_mode", int'(o_mode), 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check("mode_back", int'(o_mode), 0);

      // Mode change during RUN, then reset mid-interval
      press_run();
      step(0, 0, 1, 0);
      check("run_mode", int'(o_mode), 1);
      idle(6);
      step(0, 0, 0, 1);
      check("mid_rst_state", int'(o_state), 0);
      check("mid_rst_mode",  int'(o_mode),  0);
      step(0, 0, 0, 0);
      check("mid_rst_tick", int'(o_tick), 0);

      // Button held through reset yields one event after release
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      check("held_rst_run", int'(o_state), 1);
      idle(3);

      // Random button activity with occasional resets
      r_lvl = 0; c_lvl = 0; m_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)  r_lvl = !r_lvl;
         if ($urandom_range(0, 25) == 0) c_lvl = !c_lvl;
         if ($urandom_range(0, 8) == 0)  m_lvl = !m_lvl;
         rs_lvl = ($urandom_range(0, 299) == 0);
         step(r_lvl, c_lvl, m_lvl, rs_lvl);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
